pixel_location_gen: RTL and testbench
=====================================

Name: pixel_location_gen

Overview:
Raster-scan coordinate generator for the streaming image pipeline. Each enabled clock it advances an (x, y) pixel position left-to-right, top-to-bottom over a WIDTH x HEIGHT frame and counts completed frames. The outputs feed the pixel-processing core (threshold, connected-component labelling), which uses them as the coordinate of the pixel presented on the same cycle. It also flags row start, frame start and last pixel.

Parameters:
IMG_WIDTH, 640, pixels per row; must be >= 2.
IMG_HEIGHT, 480, rows per frame; must be >= 2.
COORD_W, 32, width of the x, y and frame outputs; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
en  in  1  advance enable; when low, all state holds
hsync  in  1  row re-sync request, sampled only when en=1
vsync  in  1  frame re-sync request, sampled only when en=1
x  out  COORD_W  column of the current pixel, 0..IMG_WIDTH-1
y  out  COORD_W  row of the current pixel, 0..IMG_HEIGHT-1
frame  out  COORD_W  number of completed frames, modulo 2^COORD_W
line_start  out  1  high while x==0
frame_start  out  1  high while x==0 and y==0
last_pixel  out  1  high while x==IMG_WIDTH-1 and y==IMG_HEIGHT-1

Behaviour:
- Reset (asynchronous, reset_n=0): x=0, y=0, frame=0. Therefore line_start=1, frame_start=1, last_pixel=0.
- x, y and frame are registers. The flags are combinational decodes of x and y only, and must not depend on en, hsync or vsync.
- x and y name the pixel being consumed in the current cycle. The first enabled cycle after reset is pixel (0,0) of frame 0.
- When en=0, all registers hold and hsync/vsync are ignored.
- Normal advance, applied on a rising edge with en=1 when no sync takes effect:
  - If x < IMG_WIDTH-1: x increments by 1.
  - Otherwise x wraps to 0 and y increments by 1.
  - If y is also IMG_HEIGHT-1: y wraps to 0 and frame increments by 1.
- frame wraps silently from 2^COORD_W-1 to 0.
- Disabling en mid-row or mid-frame and re-enabling it resumes from the held position. No pixel is skipped or repeated.
- Asserting reset_n low mid-frame returns immediately to (0,0,0). Operation resumes on the first enabled edge after reset_n returns high.
- Sync behaviour is defined under Optional Feature. Without that feature, hsync and vsync have no effect.

Optional Feature:
Macro LOC_GEN_SYNC_EN.
- Defined: the sync inputs re-align the counters. They are evaluated on an edge with en=1, in priority order, replacing the normal advance:
  1. vsync=1 and not (x==0 and y==0): x<=0, y<=0, frame<=frame+1.
  2. Else hsync=1 and x!=0: x<=0. y<=y+1, wrapping to 0 with frame+1 if y==IMG_HEIGHT-1.
  3. Else: normal advance. A sync request that arrives while already aligned (hsync at x==0, vsync at (0,0)) is redundant and is treated as a normal advance.
- Not defined: hsync and vsync are unused inputs. Behaviour is exactly the free-running raster counter.

Decomposition:
- Shared package loc_gen_pkg holds:
  - the COORD_W default;
  - the default IMG_WIDTH/IMG_HEIGHT;
  - a coord_t typedef (logic [COORD_W-1:0]).
- One sub-module is natural: wrap_counter. It is a modulo-N counter with inputs inc and clear, and outputs value and a wrap strobe (value==N-1 and inc). Instantiate it twice:
  - x counter, N=IMG_WIDTH;
  - y counter, N=IMG_HEIGHT, with inc driven by the x wrap strobe.
- frame is a plain COORD_W incrementer driven by the y wrap strobe.

Test Plan:
Run all scenarios with IMG_WIDTH=4 and IMG_HEIGHT=3.
1. Reset then en=1 for 12 cycles -> (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). After the 12th edge, x=0, y=0, frame=1. last_pixel is high only at (3,2); frame_start is high only at (0,0).
2. Hold en=0 for 5 cycles at (2,1), then re-enable -> position stays (2,1) throughout, then advances to (3,1),(0,2).
3. Assert reset_n low asynchronously at (1,2), frame=3 -> outputs read 0,0,0 before the next clock edge. line_start=1.
4. Force frame to 2^COORD_W-1 and complete a frame -> frame becomes 0 with no other side effect.
5. With LOC_GEN_SYNC_EN: hsync=1 at (2,0) -> next position is (0,1). hsync=1 at (0,1) -> next is (1,1). vsync=1 at (1,2) -> next is (0,0) with frame+1. hsync and vsync together at (2,1) -> vsync wins.
6. Without LOC_GEN_SYNC_EN: toggle hsync and vsync randomly over 24 cycles -> sequence is identical to scenario 1 repeated twice.

Source files
------------

// File: rtl/loc_gen_pkg.sv
// Shared defaults for the raster coordinate generator.
// Holds the default coordinate width, the default frame geometry and the
// coordinate type used on the generator's outputs.
package loc_gen_pkg;

    localparam int unsigned DEF_COORD_W    = 32;
    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

    typedef logic [DEF_COORD_W-1:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with a wrap strobe.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : advance by one (wraps N-1 -> 0)
//   clear        : return to 0; takes priority over inc
//   value        : current count, 0..N-1 (registered)
//   wrap_c       : combinational, high when value==N-1 and inc
module wrap_counter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value,
    output logic         wrap_c
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap_c = inc && (value == LAST);

    // Count register; clear wins so a re-sync never double-steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap_c ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/pixel_location_gen.sv
// Raster-scan pixel coordinate generator.
// Advances (x, y) left-to-right, top-to-bottom over an IMG_WIDTH x
// IMG_HEIGHT frame on every enabled clock and counts completed frames.
// x/y name the pixel consumed in the current cycle.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   en               : advance enable; all state holds when low
//   hsync, vsync     : row/frame re-sync requests (sampled only with en=1)
//   x, y, frame      : registered coordinate and completed-frame count
//   line_start       : x==0 (combinational decode of x/y only)
//   frame_start      : x==0 and y==0
//   last_pixel       : x==IMG_WIDTH-1 and y==IMG_HEIGHT-1
// Build option: define LOC_GEN_SYNC_EN to let hsync/vsync re-align the
// counters; otherwise they are ignored and the counter free-runs.
module pixel_location_gen
    import loc_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned COORD_W    = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] frame,
    output logic               line_start,
    output logic               frame_start,
    output logic               last_pixel
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    logic v_take;
    logic h_take;
    logic x_inc;
    logic x_clr;
    logic y_inc;
    logic y_clr;
    logic x_wrap;
    logic y_wrap;

`ifdef LOC_GEN_SYNC_EN
    // Redundant syncs (already aligned) fall through to a normal advance.
    assign v_take = en && vsync && !((x == '0) && (y == '0));
    assign h_take = en && hsync && !v_take && (x != '0);
`else
    logic unused_sync;
    assign unused_sync = hsync ^ vsync;
    assign v_take      = 1'b0;
    assign h_take      = 1'b0;
`endif

    // A taken sync replaces the normal advance, so inc and clear never overlap.
    assign x_inc = en && !v_take && !h_take;
    assign x_clr = v_take || h_take;
    assign y_inc = x_wrap || h_take;
    assign y_clr = v_take;

    wrap_counter #(.N(IMG_WIDTH), .W(COORD_W)) u_x_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (x_inc),
        .clear   (x_clr),
        .value   (x),
        .wrap_c  (x_wrap)
    );

    wrap_counter #(.N(IMG_HEIGHT), .W(COORD_W)) u_y_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (y_inc),
        .clear   (y_clr),
        .value   (y),
        .wrap_c  (y_wrap)
    );

    // Completed-frame count; wraps silently at 2^COORD_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame <= '0;
        end else if (y_wrap || v_take) begin
            frame <= frame + COORD_W'(1);
        end
    end

    assign line_start  = (x == '0);
    assign frame_start = (x == '0) && (y == '0);
    assign last_pixel  = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: tb/tb_pixel_location_gen.sv
// Directed bench for pixel_location_gen with a 4x3 frame and a 3-bit
// coordinate width (so the frame counter wraps after 8 frames).
module tb_pixel_location_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          hsync;
    logic          vsync;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] frame;
    logic          line_start;
    logic          frame_start;
    logic          last_pixel;

    int checks   = 0;
    int failures = 0;

    pixel_location_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .x           (x),
        .y           (y),
        .frame       (frame),
        .line_start  (line_start),
        .frame_start (frame_start),
        .last_pixel  (last_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int ef);
        check_eq({tag, ".x"}, 32'(x), 32'(ex));
        check_eq({tag, ".y"}, 32'(y), 32'(ey));
        check_eq({tag, ".frame"}, 32'(frame), 32'(ef));
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        #12;
        check_pos("reset", 0, 0, 0);
        check_eq("reset.line_start", 32'(line_start), 32'd1);
        check_eq("reset.frame_start", 32'(frame_start), 32'd1);
        check_eq("reset.last_pixel", 32'(last_pixel), 32'd0);
        reset_n = 1'b1;
        step(1);
        check_pos("reset_hold", 0, 0, 0);

        // Scenario 1: one full frame of raster order.
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_pos($sformatf("s1[%0d]", i), i % 4, i / 4, 0);
            check_eq($sformatf("s1[%0d].line_start", i), 32'(line_start), 32'((i % 4) == 0));
            check_eq($sformatf("s1[%0d].frame_start", i), 32'(frame_start), 32'(i == 0));
            check_eq($sformatf("s1[%0d].last_pixel", i), 32'(last_pixel), 32'(i == 11));
            step(1);
        end
        check_pos("s1.end", 0, 0, 1);

        // Scenario 2: hold at (2,1) for 5 cycles, then resume.
        step(6);
        check_pos("s2.at", 2, 1, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_pos($sformatf("s2.hold[%0d]", i), 2, 1, 1);
        end
        en = 1'b1;
        step(1);
        check_pos("s2.resume0", 3, 1, 1);
        step(1);
        check_pos("s2.resume1", 0, 2, 1);

        // Scenario 3: asynchronous reset at (1,2), frame 3.
        step(1);
        step(24);
        check_pos("s3.at", 1, 2, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_pos("s3.async", 0, 0, 0);
        check_eq("s3.line_start", 32'(line_start), 32'd1);
        check_eq("s3.frame_start", 32'(frame_start), 32'd1);
        en = 1'b0;
        #3;
        reset_n = 1'b1;
        step(1);
        check_pos("s3.post", 0, 0, 0);
        en = 1'b1;
        step(1);
        check_pos("s3.resume", 1, 0, 0);
        step(11);
        check_pos("s3.frame_done", 0, 0, 1);

        // Scenario 4: frame counter wraps from 7 to 0.
        step(72);
        check_pos("s4.max", 0, 0, 7);
        step(11);
        check_pos("s4.last", 3, 2, 7);
        check_eq("s4.last_pixel", 32'(last_pixel), 32'd1);
        step(1);
        check_pos("s4.wrap", 0, 0, 0);
        check_eq("s4.frame_start", 32'(frame_start), 32'd1);

`ifdef LOC_GEN_SYNC_EN
        // Scenario 5: sync re-alignment.
        step(2);
        check_pos("s5.pre_h", 2, 0, 0);
        hsync = 1'b1;
        step(1);
        check_pos("s5.hsync", 0, 1, 0);
        step(1);
        check_pos("s5.hsync_redundant", 1, 1, 0);
        hsync = 1'b0;
        step(4);
        check_pos("s5.pre_v", 1, 2, 0);
        vsync = 1'b1;
        step(1);
        check_pos("s5.vsync", 0, 0, 1);
        vsync = 1'b0;
        step(6);
        check_pos("s5.pre_hv", 2, 1, 1);
        hsync = 1'b1;
        vsync = 1'b1;
        step(1);
        check_pos("s5.hv", 0, 0, 2);
        hsync = 1'b0;
        vsync = 1'b0;
`else
        // Scenario 6: sync inputs ignored; two plain frames.
        for (int i = 0; i < 24; i++) begin
            check_pos($sformatf("s6[%0d]", i), i % 4, (i / 4) % 3, i / 12);
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            step(1);
        end
        hsync = 1'b0;
        vsync = 1'b0;
        check_pos("s6.end", 0, 0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
